// File: rtl/pid_pio_sched_pkg.sv
// Shared types and constants for the PIO write scheduler and its arbiter.
//   sched_state_e : scheduler FSM states (IDLE, WRITE, GAP)
//   PIO_DATA_ADDR : Avalon address of the PIO data register
//   WCOUNT_W      : width of the completed-write counter
//   GAP_W         : width of the inter-write gap counter (MIN_GAP 0..15)
//   idx_width()   : bit width needed to hold a requester index
package pid_pio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    localparam int PIO_DATA_ADDR = 0;
    localparam int WCOUNT_W      = 16;
    localparam int GAP_W         = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pid_pio_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after the pointer, searching upward
// and wrapping past NUM_REQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : highest-priority requester index
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request present
module rr_arbiter
    import pid_pio_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/pid_pio_write_sched.sv
// Round-robin write scheduler sharing one Avalon-MM PIO slave among
// NUM_REQ requesters. Each granted word becomes a single-cycle write to
// the PIO data register, followed by MIN_GAP forced idle cycles.
//   clk, reset   : clock, synchronous active-high reset
//   req          : per-requester level request, held until ack
//   req_data     : packed request words, requester i at [i*DATA_W +: DATA_W]
//   ack          : one-hot pulse, coincides with the requester's write
//   chipselect   : Avalon chipselect
//   write_n      : Avalon write strobe, active-low
//   address      : Avalon address, constant data register
//   writedata    : Avalon write data (holds last value when idle)
//   busy         : high while in WRITE or GAP
//   write_count  : completed writes, wraps at 16 bits
//   proto_err    : sticky, a pending request was dropped before its ack
module pid_pio_write_sched
    import pid_pio_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 2,
    parameter int MIN_GAP = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      chipselect,
    output logic                      write_n,
    output logic [ADDR_W-1:0]         address,
    output logic [DATA_W-1:0]         writedata,
    output logic                      busy,
    output logic [WCOUNT_W-1:0]       write_count,
    output logic                      proto_err
);

    localparam int IDX_W = idx_width(NUM_REQ);

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 cs_q, cs_d;
    logic                 wn_q, wn_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic [WCOUNT_W-1:0]  count_q, count_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d;
    logic                 perr_q, perr_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic [NUM_REQ-1:0]   grant_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gap_d    = gap_q;
        ack_d    = '0;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        wdata_d  = wdata_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = WRITE;
                    cs_d     = 1'b1;
                    wn_d     = 1'b0;
                    ack_d    = arb_grant;
                    wdata_d  = req_data[arb_idx*DATA_W +: DATA_W];
                    winner_d = arb_idx;
                end
            end
            WRITE: begin
                count_d = count_q + WCOUNT_W'(1);
                ptr_d   = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
                if (MIN_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_W'(MIN_GAP);
                end
            end
            GAP: begin
                // Leaving on the count of 1 yields exactly MIN_GAP GAP cycles.
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // A request counts as pending once seen high outside its grant edge
        // and its ack cycle; a requester may drop its line in the ack cycle.
        grant_fire = (state_q == IDLE) ? arb_grant : '0;
        pend_d     = req & ~grant_fire & ~ack_q;
        perr_d     = perr_q | (|(pend_q & ~req));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            gap_q    <= '0;
            ack_q    <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            pend_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gap_q    <= gap_d;
            ack_q    <= ack_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            perr_q   <= perr_d;
        end
    end

    assign ack         = ack_q;
    assign chipselect  = cs_q;
    assign write_n     = wn_q;
    assign address     = ADDR_W'(PIO_DATA_ADDR);
    assign writedata   = wdata_q;
    assign busy        = busy_q;
    assign write_count = count_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_pid_pio_write_sched.sv
// Scoreboard bench for pid_pio_write_sched: instance A uses MIN_GAP=2,
// instance B uses MIN_GAP=0. Stimulus pushes the expected (requester, data)
// of each write; per-instance monitors pop and compare on every Avalon write.
module tb_pid_pio_write_sched;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_a, reset_b;
    logic [N-1:0]    req_a, req_b;
    logic [N*DW-1:0] data_a, data_b;
    logic [N-1:0]    ack_a, ack_b;
    logic            cs_a, cs_b, wn_a, wn_b;
    logic [1:0]      addr_a, addr_b;
    logic [DW-1:0]   wd_a, wd_b;
    logic            busy_a, busy_b;
    logic [15:0]     cnt_a, cnt_b;
    logic            perr_a, perr_b;

    pid_pio_write_sched #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(2), .MIN_GAP(2)) dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .req_data(data_a), .ack(ack_a),
        .chipselect(cs_a), .write_n(wn_a), .address(addr_a), .writedata(wd_a),
        .busy(busy_a), .write_count(cnt_a), .proto_err(perr_a)
    );

    pid_pio_write_sched #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(2), .MIN_GAP(0)) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .req_data(data_b), .ack(ack_b),
        .chipselect(cs_b), .write_n(wn_b), .address(addr_b), .writedata(wd_b),
        .busy(busy_b), .write_count(cnt_b), .proto_err(perr_b)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int idx, input logic [31:0] d);
        exp_t e;
        e.idx = idx; e.data = d;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int idx, input logic [31:0] d);
        exp_t e;
        e.idx = idx; e.data = d;
        q_b.push_back(e);
    endtask

    task automatic reset_dut_a();
        reset_a = 1'b1;
        req_a   = '0;
        tick();
        tick();
        reset_a = 1'b0;
    endtask

    // Bounded wait for ack of requester idx on instance A; returns in the ack cycle.
    task automatic wait_ack_a(input int idx, input int budget);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (ack_a[idx]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_ack_%0d: no ack within %0d cycles", idx, budget);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cs_a && !wn_a) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL A_unexpected_write: writedata=%h ack=%b, expected no write", wd_a, ack_a);
                end else begin
                    e_a = q_a.pop_front();
                    chk("A_writedata", wd_a, e_a.data);
                    chk("A_ack", ack_a, 64'(1) << e_a.idx);
                    chk("A_address", addr_a, 0);
                end
            end else begin
                chk("A_ack_without_write", ack_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (cs_b && !wn_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL B_unexpected_write: writedata=%h ack=%b, expected no write", wd_b, ack_b);
                end else begin
                    e_b = q_b.pop_front();
                    chk("B_writedata", wd_b, e_b.data);
                    chk("B_ack", ack_b, 64'(1) << e_b.idx);
                end
            end else begin
                chk("B_ack_without_write", ack_b, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        reset_a = 1'b1; reset_b = 1'b1;
        req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        tick();
        tick();
        reset_a = 1'b0;
        mon_en  = 1'b1;

        // Reset values
        chk("rst_chipselect", cs_a, 0);
        chk("rst_write_n", wn_a, 1);
        chk("rst_writedata", wd_a, 0);
        chk("rst_ack", ack_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_proto_err", perr_a, 0);

        // Single request: one-cycle latency, busy for WRITE + 2 GAP cycles
        push_a(0, 32'h0000_1234);
        data_a[0 +: 32] = 32'h0000_1234;
        req_a = 4'b0001;
        tick();
        chk("single_cs", cs_a, 1);
        chk("single_write_n", wn_a, 0);
        chk("single_busy_write", busy_a, 1);
        req_a = 4'b0000;
        tick();
        chk("single_cs_off", cs_a, 0);
        chk("single_count", cnt_a, 1);
        chk("single_busy_gap1", busy_a, 1);
        tick();
        chk("single_busy_gap2", busy_a, 1);
        tick();
        chk("single_busy_idle", busy_a, 0);
        chk("single_wd_hold", wd_a, 32'h0000_1234);

        // Full contention: grants 0,1,2,3,0 every 4 cycles
        reset_dut_a();
        for (int i = 0; i < N; i++) data_a[i*DW +: DW] = 32'h1111_0000 + 32'(i);
        for (int g = 0; g < 5; g++)
            push_a(order[g], (g == 4) ? 32'h0000_00A5 : 32'h1111_0000 + 32'(order[g]));
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_cs", cs_a, 1);
            chk("rr_ack", ack_a, 64'(1) << order[g]);
            if (g == 0) data_a[0 +: DW] = 32'h0000_00A5;
            if (g == 4) chk("rr_count_before", cnt_a, 4);
            if (g < 4) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("rr_gap_cs", cs_a, 0);
                end
            end
        end
        tick();
        chk("rr_count_after", cnt_a, 5);
        chk("rr_no_proto_err", perr_a, 0);

        // Pointer fairness: after granting 2, req=0101 wraps to requester 0
        reset_dut_a();
        data_a[0 +: DW]  = 32'hAAAA_0000;
        data_a[64 +: DW] = 32'hCCCC_0002;
        push_a(2, 32'hCCCC_0002);
        req_a = 4'b0100;
        wait_ack_a(2, 8);
        req_a = 4'b0000;
        tick(); tick(); tick();
        push_a(0, 32'hAAAA_0000);
        data_a[64 +: DW] = 32'hCCCC_0022;
        push_a(2, 32'hCCCC_0022);
        req_a = 4'b0101;
        tick();
        chk("fair_ack_wrap", ack_a, 4'b0001);
        req_a = 4'b0100;
        wait_ack_a(2, 8);
        req_a = 4'b0000;
        tick(); tick(); tick();
        chk("fair_no_proto_err", perr_a, 0);

        // Protocol error: req[1] raised then dropped while requester 0 writes
        reset_dut_a();
        push_a(0, 32'h0BAD_0000);
        data_a[0 +: DW] = 32'h0BAD_0000;
        req_a = 4'b0001;
        tick();
        chk("perr_write_cs", cs_a, 1);
        req_a = 4'b0010;
        tick();
        req_a = 4'b0000;
        tick();
        chk("perr_set", perr_a, 1);
        for (int c = 0; c < 6; c++) tick();
        chk("perr_sticky", perr_a, 1);
        chk("perr_count", cnt_a, 1);

        // Reset in the WRITE cycle, then requester 3 wins first
        push_a(0, 32'h5555_0000);
        data_a[0 +: DW] = 32'h5555_0000;
        req_a = 4'b0001;
        tick();
        chk("midrst_cs", cs_a, 1);
        reset_a = 1'b1;
        req_a   = 4'b1000;
        data_a[96 +: DW] = 32'h3333_0003;
        tick();
        chk("midrst_cs_off", cs_a, 0);
        chk("midrst_write_n", wn_a, 1);
        chk("midrst_count", cnt_a, 0);
        chk("midrst_proto_err", perr_a, 0);
        chk("midrst_busy", busy_a, 0);
        reset_a = 1'b0;
        push_a(3, 32'h3333_0003);
        tick();
        chk("midrst_grant3", ack_a, 4'b1000);
        req_a = 4'b0000;
        tick(); tick(); tick();

        // MIN_GAP=0 instance: writes on alternating cycles, order 0,1,0,1
        reset_b = 1'b0;
        tick();
        data_b[0 +: DW]  = 32'hB000_0000;
        data_b[32 +: DW] = 32'hB000_0001;
        push_b(0, 32'hB000_0000);
        push_b(1, 32'hB000_0001);
        push_b(0, 32'hB000_0002);
        push_b(1, 32'hB000_0003);
        req_b = 4'b0011;
        tick();
        chk("g0_ack_0", ack_b, 4'b0001);
        data_b[0 +: DW] = 32'hB000_0002;
        tick();
        chk("g0_idle_1", cs_b, 0);
        tick();
        chk("g0_ack_1", ack_b, 4'b0010);
        data_b[32 +: DW] = 32'hB000_0003;
        tick();
        chk("g0_idle_2", cs_b, 0);
        tick();
        chk("g0_ack_2", ack_b, 4'b0001);
        req_b = 4'b0010;
        tick();
        chk("g0_idle_3", cs_b, 0);
        tick();
        chk("g0_ack_3", ack_b, 4'b0010);
        req_b = 4'b0000;
        tick();
        chk("g0_count", cnt_b, 4);
        chk("g0_proto_err", perr_b, 0);

        tick(); tick(); tick();
        chk("A_scoreboard_drained", q_a.size(), 0);
        chk("B_scoreboard_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
